// File: rtl/cnn_buf_pkg.sv
// Shared definitions for the RAM stream buffer controller.
//   RD_LATENCY_DEF : default RAM read latency in cycles
//   cnt_w()        : occupancy counter width for a given RAM address width
//   skid_cnt_w()   : entry counter width for a skid FIFO of a given depth
//   credit_ok()    : read-issue credit check against the output skid space
package cnn_buf_pkg;

    localparam int RD_LATENCY_DEF = 2;

    // Occupancy runs 0..2^addr_width inclusive, so it needs one extra bit.
    function automatic int cnt_w(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int skid_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A read may be issued only if every word already in flight, every word
    // held in the skid FIFO, and the new word still fit. An entry is charged
    // as still occupied unless this cycle pops it.
    function automatic logic credit_ok(input int inflight, input int held,
                                       input logic pop, input int depth);
        return (inflight + held + (pop ? 0 : 1)) < depth;
    endfunction

endpackage

// File: rtl/ram_stream_ctrl_if.sv
// Valid/ready stream bundle.
//   valid : word present (source to sink)
//   ready : sink accepts the word (sink to source)
//   data  : word payload, DATA_WIDTH bits
// modport master drives valid/data, modport slave drives ready.
interface ram_stream_ctrl_if #(
    parameter int DATA_WIDTH = 10
) ();

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/stream_skid_fifo.sv
// Register-based FIFO that catches RAM read data on the output side.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write one entry
//   pop        : remove the head entry
//   dout       : head entry (zero after reset)
//   cnt        : number of entries held
//   empty      : cnt == 0
// The caller guarantees no push while full and no pop while empty.
module stream_skid_fifo
    import cnn_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic                        pop,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic [skid_cnt_w(DEPTH)-1:0] cnt,
    output logic                        empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign dout  = mem[rd_ptr];
    assign empty = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_ctrl.sv
// Stream-side controller for a pointer-addressed RAM buffer.
// Input stream words become RAM write strobes; RAM read strobes are issued
// against skid-FIFO credits so every returned word has a place to land, and
// the skid FIFO drives the output stream.
//   clk, reset   : clock, synchronous active-high reset (also resets RAM pointers)
//   s            : input stream (slave modport)
//   m            : output stream (master modport)
//   ram_wr_req   : RAM write strobe, ram_wr_data is s.data passed through
//   ram_rd_req   : RAM read strobe, ram_rd_data returns RD_LATENCY cycles later
//   count        : words held in RAM not yet read; full / empty flags
// Optional (macro RAM_STREAM_CTRL_STATS_EN):
//   max_count    : high-water mark of count since reset
//   stall_cnt    : saturating count of cycles with s.valid && !s.ready
module ram_stream_ctrl
    import cnn_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int SKID_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    ram_stream_ctrl_if.slave              s,
    ram_stream_ctrl_if.master             m,
    output logic                          ram_wr_req,
    output logic [DATA_WIDTH-1:0]         ram_wr_data,
    output logic                          ram_rd_req,
    input  logic [DATA_WIDTH-1:0]         ram_rd_data,
    output logic [cnt_w(ADDR_WIDTH)-1:0]  count,
    output logic                          full,
    output logic                          empty
`ifdef RAM_STREAM_CTRL_STATS_EN
    ,
    output logic [cnt_w(ADDR_WIDTH)-1:0]  max_count,
    output logic [31:0]                   stall_cnt
`endif
);

    localparam int CW = cnt_w(ADDR_WIDTH);
    localparam int SW = skid_cnt_w(SKID_DEPTH);
    localparam logic [CW-1:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic                  wr_fire;
    logic                  pop;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic [SW-1:0]         skid_cnt;
    logic                  skid_empty;
    int                    inflight;

    assign full        = (count == CAPACITY);
    assign empty       = (count == '0);
    assign s.ready     = !full;
    assign wr_fire     = s.valid && s.ready;
    assign ram_wr_req  = wr_fire;
    assign ram_wr_data = s.data;

    assign m.valid  = !skid_empty;
    assign pop      = m.valid && m.ready;
    assign inflight = $countones(rd_pipe);

    assign ram_rd_req = !empty && credit_ok(inflight, int'(skid_cnt), pop, SKID_DEPTH);

    // A write and a read in the same cycle cancel; the RAM makes a word
    // written this cycle readable next cycle, which the registered count
    // already reflects.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (wr_fire && !ram_rd_req) begin
            count <= count + 1'b1;
        end else if (!wr_fire && ram_rd_req) begin
            count <= count - 1'b1;
        end
    end

    // Bit k set means a read issued k+1 cycles ago; the top bit marks the
    // cycle its data is on ram_rd_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= (rd_pipe << 1) | RD_LATENCY'(ram_rd_req);
        end
    end

    stream_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (rd_pipe[RD_LATENCY-1]),
        .din   (ram_rd_data),
        .pop   (pop),
        .dout  (m.data),
        .cnt   (skid_cnt),
        .empty (skid_empty)
    );

`ifdef RAM_STREAM_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            max_count <= '0;
            stall_cnt <= '0;
        end else begin
            if (count > max_count) begin
                max_count <= count;
            end
            if (s.valid && !s.ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Self-checking bench for ram_stream_ctrl with an 8-word RAM model
// (ADDR_WIDTH=3) so fill and pointer wrap are reachable quickly.
// Statistics checks are compiled in with RAM_STREAM_CTRL_STATS_EN.
module tb_ram_stream_ctrl;

    localparam int DW   = 10;
    localparam int AW   = 3;
    localparam int RDL  = 2;
    localparam int SKID = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ram_wr_req;
    logic [DW-1:0] ram_wr_data;
    logic          ram_rd_req;
    logic [DW-1:0] ram_rd_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
`ifdef RAM_STREAM_CTRL_STATS_EN
    logic [AW:0]   max_count;
    logic [31:0]   stall_cnt;
`endif

    ram_stream_ctrl_if #(.DATA_WIDTH(DW)) s_bus ();
    ram_stream_ctrl_if #(.DATA_WIDTH(DW)) m_bus ();

    ram_stream_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (RDL),
        .SKID_DEPTH (SKID)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s           (s_bus),
        .m           (m_bus),
        .ram_wr_req  (ram_wr_req),
        .ram_wr_data (ram_wr_data),
        .ram_rd_req  (ram_rd_req),
        .ram_rd_data (ram_rd_data),
        .count       (count),
        .full        (full),
        .empty       (empty)
`ifdef RAM_STREAM_CTRL_STATS_EN
        ,
        .max_count   (max_count),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: pointers reset with the controller, two-register read path.
    logic [DW-1:0] ram_mem [1 << AW];
    logic [AW-1:0] ram_wp, ram_rp;
    logic [DW-1:0] rd_d1, rd_d2;

    always @(posedge clk) begin
        if (reset) begin
            ram_wp <= '0;
            ram_rp <= '0;
            rd_d1  <= '0;
            rd_d2  <= '0;
        end else begin
            if (ram_wr_req) begin
                ram_mem[ram_wp] <= ram_wr_data;
                ram_wp          <= ram_wp + 1'b1;
            end
            if (ram_rd_req) begin
                rd_d1  <= ram_mem[ram_rp];
                ram_rp <= ram_rp + 1'b1;
            end
            rd_d2 <= rd_d1;
        end
    end
    assign ram_rd_data = rd_d2;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;
    int ovf_cnt  = 0;
    int bad_rd   = 0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard and invariants, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (s_bus.valid && s_bus.ready) exp_q.push_back(s_bus.data);
            if (m_bus.valid && m_bus.ready) begin
                rx_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_order: got 0x%0h, expected no output", m_bus.data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_bus.data !== e) begin
                        n_fail++;
                        $display("FAIL sb_order: got 0x%0h, expected 0x%0h", m_bus.data, e);
                    end
                end
            end
            if ((int'(dut.skid_cnt) == SKID) && dut.rd_pipe[RDL-1] && !(m_bus.valid && m_bus.ready))
                ovf_cnt++;
            if (ram_rd_req && empty) bad_rd++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string nm, input int budget);
        int quiet = 0;
        s_bus.valid = 1'b0;
        m_bus.ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (count == '0 && !m_bus.valid) quiet++;
            else quiet = 0;
            if (quiet >= 4) break;
        end
        chk(nm, 64'(quiet >= 4), 64'd1);
    endtask

    task automatic push_n(input string nm, input logic [DW-1:0] base, input int n, input logic mr);
        int k = 0;
        for (int i = 0; i < 4 * n + 10 && k < n; i++) begin
            s_bus.valid = 1'b1;
            s_bus.data  = base + DW'(k);
            m_bus.ready = mr;
            #1;
            if (s_bus.ready) k++;
            tick();
        end
        s_bus.valid = 1'b0;
        chk(nm, 64'(k), 64'(n));
    endtask

    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic [3:0]    e_flags;  // {s_ready, ram_wr_req, ram_rd_req, m_valid}
        logic [DW-1:0] e_data;
        logic [AW:0]   e_cnt;
    } vec_t;

    vec_t vec [10];

    initial begin
        logic [17:0] got, exp;
        int lat, sent, rx_base;

        vec[0] = '{1'b1, 10'h001, 1'b1, 4'b1100, 10'h000, 4'd0};
        vec[1] = '{1'b1, 10'h002, 1'b1, 4'b1110, 10'h000, 4'd1};
        vec[2] = '{1'b1, 10'h003, 1'b1, 4'b1110, 10'h000, 4'd1};
        vec[3] = '{1'b1, 10'h004, 1'b1, 4'b1110, 10'h000, 4'd1};
        vec[4] = '{1'b1, 10'h005, 1'b1, 4'b1111, 10'h001, 4'd1};
        vec[5] = '{1'b0, 10'h000, 1'b1, 4'b1011, 10'h002, 4'd1};
        vec[6] = '{1'b0, 10'h000, 1'b1, 4'b1001, 10'h003, 4'd0};
        vec[7] = '{1'b0, 10'h000, 1'b1, 4'b1001, 10'h004, 4'd0};
        vec[8] = '{1'b0, 10'h000, 1'b1, 4'b1001, 10'h005, 4'd0};
        vec[9] = '{1'b0, 10'h000, 1'b1, 4'b1000, 10'h000, 4'd0};

        reset = 1'b1;
        s_bus.valid = 1'b0;
        s_bus.data  = '0;
        m_bus.ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_s_ready",    64'(s_bus.ready), 64'd1);
        chk("rst_m_valid",    64'(m_bus.valid), 64'd0);
        chk("rst_m_data",     64'(m_bus.data),  64'd0);
        chk("rst_ram_wr_req", 64'(ram_wr_req),  64'd0);
        chk("rst_ram_rd_req", 64'(ram_rd_req),  64'd0);
        chk("rst_count",      64'(count),       64'd0);
        chk("rst_empty",      64'(empty),       64'd1);
        chk("rst_full",       64'(full),        64'd0);

        // Five words through an idle system with m_ready held high.
        for (int i = 0; i < 10; i++) begin
            s_bus.valid = vec[i].sv;
            s_bus.data  = vec[i].sd;
            m_bus.ready = vec[i].mr;
            #1;
            got = {s_bus.ready, ram_wr_req, ram_rd_req, m_bus.valid,
                   (m_bus.valid ? m_bus.data : 10'h000), count};
            exp = {vec[i].e_flags, vec[i].e_data, vec[i].e_cnt};
            chk($sformatf("vec_row%0d", i), 64'(got), 64'(exp));
            tick();
        end
        drain("drain_vec", 40);

        // Reset with three words in flight; the next word is the first out.
        for (int i = 0; i < 3; i++) begin
            s_bus.valid = 1'b1;
            s_bus.data  = DW'(10'h301 + i);
            m_bus.ready = 1'b1;
            tick();
        end
        reset = 1'b1;
        s_bus.valid = 1'b0;
        tick();
        reset = 1'b0;
        s_bus.valid = 1'b1;
        s_bus.data  = 10'h2AA;
        #1;
        chk("midrst_m_valid", 64'(m_bus.valid), 64'd0);
        chk("midrst_count",   64'(count),       64'd0);
        tick();
        s_bus.valid = 1'b0;
        lat = 1;
        while (!m_bus.valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("midrst_latency",    64'(lat),        64'd4);
        chk("midrst_first_data", 64'(m_bus.data), 64'h2AA);
        drain("drain_midrst", 40);

        // Fill to 6 with output blocked (3 words park in the skid FIFO).
        push_n("fill6_accepts", 10'h200, 9, 1'b0);
        repeat (3) tick();
        #1;
        chk("fill6_count",  64'(count),       64'd6);
        chk("fill6_mvalid", 64'(m_bus.valid), 64'd1);
        chk("fill6_mdata",  64'(m_bus.data),  64'h200);
        m_bus.ready = 1'b1;
        #1;
        chk("fill6_rd_on_pop", 64'(ram_rd_req), 64'd1);
        tick();
        m_bus.ready = 1'b0;
        repeat (3) tick();
        #1;
        chk("count5_start", 64'(count), 64'd5);
        // Simultaneous write and read: count holds and output is continuous.
        for (int i = 0; i < 10; i++) begin
            s_bus.valid = 1'b1;
            s_bus.data  = DW'(10'h210 + i);
            m_bus.ready = 1'b1;
            #1;
            chk($sformatf("wr_rd_count_c%0d", i), 64'(count), 64'd5);
            chk($sformatf("wr_rd_mvalid_c%0d", i), 64'(m_bus.valid), 64'd1);
            tick();
        end
        drain("drain_count5", 60);
`ifdef RAM_STREAM_CTRL_STATS_EN
        chk("stats_max_count_6", 64'(max_count), 64'd6);
        chk("stats_stall_0",     64'(stall_cnt), 64'd0);
`endif

        // Full: 8 in RAM + 3 in skid, then the 12th word stalls 6 cycles.
        push_n("full_accepts", 10'h100, 11, 1'b0);
        for (int i = 0; i < 5; i++) begin
            s_bus.valid = 1'b1;
            s_bus.data  = 10'h10B;
            m_bus.ready = 1'b0;
            #1;
            chk($sformatf("full_stall_c%0d", i), 64'(s_bus.ready), 64'd0);
            tick();
        end
        #1;
        chk("full_count",  64'(count),       64'd8);
        chk("full_flag",   64'(full),        64'd1);
        chk("full_no_rd",  64'(ram_rd_req),  64'd0);
        chk("full_mdata",  64'(m_bus.data),  64'h100);
        m_bus.ready = 1'b1;
        #1;
        chk("full_pop_rd",     64'(ram_rd_req),  64'd1);
        chk("full_still_full", 64'(s_bus.ready), 64'd0);
        tick();
        #1;
        chk("full_freed_ready", 64'(s_bus.ready), 64'd1);
        chk("full_freed_count", 64'(count),       64'd7);
        chk("full_freed_wr",    64'(ram_wr_req),  64'd1);
        tick();
        drain("drain_full", 60);
`ifdef RAM_STREAM_CTRL_STATS_EN
        chk("stats_stall_6",     64'(stall_cnt), 64'd6);
        chk("stats_max_count_8", 64'(max_count), 64'd8);
`endif

        // Random backpressure, 1000 words, many pointer wraps.
        rx_base = rx_cnt;
        sent = 0;
        for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
            s_bus.valid = ($urandom_range(0, 3) != 0);
            s_bus.data  = DW'(sent);
            m_bus.ready = ($urandom_range(0, 2) != 0);
            #1;
            if (s_bus.valid && s_bus.ready) sent++;
            tick();
        end
        chk("rand_sent", 64'(sent), 64'd1000);
        drain("drain_rand", 200);
        chk("rand_received", 64'(rx_cnt - rx_base), 64'd1000);

        chk("skid_overflow_events", 64'(ovf_cnt),      64'd0);
        chk("rd_req_while_empty",   64'(bad_rd),       64'd0);
        chk("sb_leftover",          64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
